// File: rtl/fft_frame_pkg.sv
// fft_frame_pkg: frame geometry defaults, sample type and frame-source FSM
// states shared by the frame source, the fft_top wrapper and its consumer.
package fft_frame_pkg;

  localparam int FRAME_LEN_DEF  = 256;
  localparam int FIFO_DEPTH_DEF = 512;
  localparam int DW_DEF         = 16;

  typedef logic [DW_DEF-1:0] sample_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/fft_frame_source_if.sv
// fft_frame_source_if: frame stream from the frame source into fft_top
// (xin/xvalid/xready/xlast, AXI-Stream style beat on xvalid & xready).
interface fft_frame_source_if
  import fft_frame_pkg::*;
#(
  parameter int DW = DW_DEF
) ();

  logic [DW-1:0] xin;
  logic          xvalid;
  logic          xready;
  logic          xlast;

  modport master (
    output xin,
    output xvalid,
    output xlast,
    input  xready
  );

  modport slave (
    input  xin,
    input  xvalid,
    input  xlast,
    output xready
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock sample FIFO with a registered first-word-
// fall-through head. o_head always shows the oldest stored word one edge
// after it becomes the oldest, so the consumer can use it without a read
// request. A push into a full FIFO is accepted when a pop happens in the
// same cycle.
module sync_fifo_fwft
  import fft_frame_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [DW-1:0]          i_data,
  output logic [DW-1:0]          o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_head;

  logic          w_doPush;
  logic          w_doPop;
  logic [AW-1:0] w_rdPtrNext;

  assign w_doPop     = i_pop & (r_count != '0);
  assign w_doPush    = i_push & ((r_count != FULL_LVL) | w_doPop);
  assign w_rdPtrNext = r_rdPtr + AW'(w_doPop);

  // Sample storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Read/write pointers wrap modulo DEPTH; occupancy tracks push minus pop exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      r_rdPtr <= w_rdPtrNext;
      unique case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head register preloads the word at the next read address, bypassing the write port when that slot is being filled now.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= '0;
    end else if (w_doPush && (r_wrPtr == w_rdPtrNext)) begin
      r_head <= i_data;
    end else begin
      r_head <= r_mem[w_rdPtrNext];
    end
  end

  assign o_head  = r_head;
  assign o_full  = (r_count == FULL_LVL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fft_frame_source.sv
// fft_frame_source: buffers free-running audio samples and emits fixed-length
// frames to fft_top. A frame is only started once a whole frame is buffered,
// so xvalid never drops inside a frame and xlast marks every frame end.
// Frames follow each other without a bubble while enough data is queued.
module fft_frame_source
  import fft_frame_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DW         = DW_DEF
) (
  input  logic                        sclk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [DW-1:0]               sample_in,
  input  logic                        sample_valid,
  fft_frame_source_if.master          xbus,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic                        overflow,
  output logic [15:0]                 frames_sent
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] FRAME_LVL = CW'(FRAME_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

  state_t        r_state;
  state_t        w_nextState;
  logic [BW-1:0] r_beatCnt;
  logic [BW-1:0] w_beatNext;
  logic          r_haveFrame;
  logic          r_overflow;
  logic [15:0]   r_framesSent;

  logic          w_pushReq;
  logic          w_push;
  logic          w_pop;
  logic          w_xvalid;
  logic          w_last;
  logic          w_full;
  logic          w_empty;
  logic [DW-1:0] w_head;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_countAfter;

  sync_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (sclk),
    .rst_n   (rst_n),
    .i_push  (w_pushReq),
    .i_pop   (w_pop),
    .i_data  (sample_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_pushReq    = enable & sample_valid;
  assign w_xvalid     = (r_state == STREAM) & ~w_empty;
  assign w_pop        = w_xvalid & xbus.xready;
  assign w_push       = w_pushReq & (~w_full | w_pop);
  assign w_last       = w_xvalid & (r_beatCnt == LAST_BEAT);
  assign w_countAfter = w_count + CW'(w_push) - CW'(w_pop);

  // Frame sequencing: wait for a full frame (seen on two consecutive edges so the FWFT head has settled), then stream; at a frame end keep going only if another full frame remains.
  always_comb begin
    w_nextState = r_state;
    w_beatNext  = r_beatCnt;
    unique case (r_state)
      IDLE: begin
        if (r_haveFrame && (w_count >= FRAME_LVL)) begin
          w_nextState = STREAM;
          w_beatNext  = '0;
        end
      end
      STREAM: begin
        if (w_pop) begin
          if (w_last) begin
            w_beatNext = '0;
            if (w_countAfter < FRAME_LVL) begin
              w_nextState = IDLE;
            end
          end else begin
            w_beatNext = r_beatCnt + BW'(1);
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_beatNext  = '0;
      end
    endcase
  end

  // State, beat position, threshold history, sticky overflow and completed-frame count.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_beatCnt    <= '0;
      r_haveFrame  <= 1'b0;
      r_overflow   <= 1'b0;
      r_framesSent <= '0;
    end else begin
      r_state     <= w_nextState;
      r_beatCnt   <= w_beatNext;
      r_haveFrame <= (w_count >= FRAME_LVL);
      if (w_pushReq && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      if (w_pop && w_last) begin
        r_framesSent <= r_framesSent + 16'd1;
      end
    end
  end

  assign xbus.xin     = w_head;
  assign xbus.xvalid  = w_xvalid;
  assign xbus.xlast   = w_last;
  assign fill_level   = w_count;
  assign overflow     = r_overflow;
  assign frames_sent  = r_framesSent;

endmodule
